// File: rtl/mem_access_unit_if.sv
// Data-bus link between the MEM-stage load/store engine and memory.
// Request is valid/ready; one response pulse per accepted request.
interface mem_access_unit_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            bus_req_valid;
  logic            bus_req_ready;
  logic            bus_req_we;
  logic [XLEN-1:0] bus_req_addr;
  logic [XLEN-1:0] bus_req_wdata;
  logic [BE_W-1:0] bus_req_be;
  logic            bus_rsp_valid;
  logic [XLEN-1:0] bus_rsp_rdata;
  logic            bus_rsp_err;

  modport master (
    output bus_req_valid,
    input  bus_req_ready,
    output bus_req_we,
    output bus_req_addr,
    output bus_req_wdata,
    output bus_req_be,
    input  bus_rsp_valid,
    input  bus_rsp_rdata,
    input  bus_rsp_err
  );

  modport slave (
    input  bus_req_valid,
    output bus_req_ready,
    input  bus_req_we,
    input  bus_req_addr,
    input  bus_req_wdata,
    input  bus_req_be,
    output bus_rsp_valid,
    output bus_rsp_rdata,
    output bus_rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one bus transaction per memory op,
// stalls the pipe until it completes, returns extended load data.
module mem_access_unit #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  mem_access_unit_if.master bus,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned_ld,
  output logic            misaligned_st,
  output logic            access_fault
);

  localparam int OFFW = $clog2(BE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_f3;
  logic [OFFW-1:0] r_off;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [BE_W-1:0] r_be;
  logic [XLEN-1:0] r_ld;
  logic            r_mis_ld;
  logic            r_mis_st;
  logic            r_fault;

  logic            w_start;
  logic [1:0]      w_sz;
  logic            w_mis;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wd;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_ext;

  // A 32-bit core has no doubleword; treat size 11 as a word.
  assign w_sz = (XLEN == 32 && funct3[1:0] == 2'b11)
              ? 2'b10 : funct3[1:0];

  assign w_mis = (w_sz == 2'b01 && addr[0])
              || (w_sz == 2'b10 && |addr[1:0])
              || (w_sz == 2'b11 && |addr[2:0]);

  assign w_start = valid_in & (mem_read | mem_write) & ~flush
                 & ~reset & (r_state == S_IDLE);

  assign stall = w_start
              || (r_state != S_IDLE && r_state != S_DONE);

  // Byte-enable and lane-replicated store data for the new request.
  always_comb begin
    w_be = '1;
    w_wd = wdata;
    case (w_sz)
      2'b00: begin
        w_be = BE_W'(1) << addr[OFFW-1:0];
        w_wd = {BE_W{wdata[7:0]}};
      end
      2'b01: begin
        w_be = BE_W'(2'b11) << addr[OFFW-1:0];
        w_wd = {(BE_W/2){wdata[15:0]}};
      end
      2'b10: begin
        w_be = BE_W'(4'hF) << addr[OFFW-1:0];
        w_wd = {(XLEN/32){wdata[31:0]}};
      end
      default: begin
        w_be = '1;
        w_wd = wdata;
      end
    endcase
  end

  assign w_sh = bus.bus_rsp_rdata >> {r_off, 3'b000};

  // Pick the addressed lane and sign/zero-extend per funct3.
  always_comb begin
    w_ext = w_sh;
    case (r_f3)
      3'b000:  w_ext = XLEN'($signed(w_sh[7:0]));
      3'b001:  w_ext = XLEN'($signed(w_sh[15:0]));
      3'b010:  w_ext = XLEN'($signed(w_sh[31:0]));
      3'b100:  w_ext = XLEN'(w_sh[7:0]);
      3'b101:  w_ext = XLEN'(w_sh[15:0]);
      3'b110:  w_ext = XLEN'(w_sh[31:0]);
      default: w_ext = w_sh;
    endcase
  end

  // Transaction FSM with registered bus request, result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_f3     <= '0;
      r_off    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_ld     <= '0;
      r_mis_ld <= 1'b0;
      r_mis_st <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_f3     <= funct3;
            r_off    <= addr[OFFW-1:0];
            r_we     <= mem_write;
            r_fault  <= 1'b0;
            r_mis_ld <= w_mis & ~mem_write;
            r_mis_st <= w_mis & mem_write;
            if (w_mis) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              r_wdata <= w_wd;
              r_be    <= w_be;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Accepted-and-flushed still owes a response: drain it.
          if (bus.bus_req_ready) begin
            r_state <= flush ? S_DRAIN : S_WAIT;
          end else if (flush) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.bus_rsp_valid) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_ld    <= w_ext;
              r_fault <= bus.bus_rsp_err;
              r_state <= S_DONE;
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.bus_rsp_valid) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          r_mis_ld <= 1'b0;
          r_mis_st <= 1'b0;
          r_fault  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req_valid = (r_state == S_REQ);
  assign bus.bus_req_we    = r_we;
  assign bus.bus_req_addr  = r_addr;
  assign bus.bus_req_wdata = r_wdata;
  assign bus.bus_req_be    = r_be;

  assign done          = (r_state == S_DONE);
  assign load_data     = r_ld;
  assign misaligned_ld = r_mis_ld;
  assign misaligned_st = r_mis_st;
  assign access_fault  = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32).
// Bus responder is driven by hand inside each scenario task.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned_ld;
  logic        misaligned_st;
  logic        access_fault;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit_if #(.XLEN(32)) bus_if ();

  mem_access_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .flush         (flush),
    .bus           (bus_if),
    .stall         (stall),
    .done          (done),
    .load_data     (load_data),
    .misaligned_ld (misaligned_ld),
    .misaligned_st (misaligned_st),
    .access_fault  (access_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
    flush     = 1'b0;
  endtask

  task automatic start_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] wd);
    valid_in  = 1'b1;
    mem_read  = ~we;
    mem_write = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  // Runs one aligned access with ready=1 and a next-cycle response.
  // Returns what was seen in the completion cycle; ends one cycle later.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] a,
                            input logic [31:0] wd,
                            input logic [31:0] rd,
                            input logic er,
                            output logic seen,
                            output logic [31:0] ld,
                            output logic flt);
    bit got;
    seen = 1'b0;
    ld   = '0;
    flt  = 1'b0;
    got  = 1'b0;
    bus_if.bus_req_ready = 1'b1;
    start_op(we, f3, a, wd);
    step();
    idle_inputs();
    for (int i = 0; i < 8 && !got; i++) begin
      if (bus_if.bus_req_valid) got = 1'b1;
      else step();
    end
    if (!got) return;
    step();
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = rd;
    bus_if.bus_rsp_err   = er;
    step();
    bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rsp_err   = 1'b0;
    seen = done;
    ld   = load_data;
    flt  = access_fault;
    step();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rsp_rdata = '0;
    bus_if.bus_rsp_err   = 1'b0;
    step();
    step();
    n_chk++;
    if ({stall, done, misaligned_ld, misaligned_st, access_fault}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {stall, done, misaligned_ld, misaligned_st, access_fault});
    end
    n_chk++;
    if (load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ld: got %h want 0", load_data);
    end
    n_chk++;
    if ({bus_if.bus_req_valid, bus_if.bus_req_we, bus_if.bus_req_addr,
         bus_if.bus_req_wdata, bus_if.bus_req_be} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: v=%b we=%b a=%h d=%h be=%b want all 0",
               bus_if.bus_req_valid, bus_if.bus_req_we,
               bus_if.bus_req_addr, bus_if.bus_req_wdata,
               bus_if.bus_req_be);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_store_byte;
    bus_if.bus_req_ready = 1'b1;
    start_op(1'b1, 3'b000, 32'h1003, 32'h0000_00A5);
    #1;
    n_chk++;
    if ({stall, bus_if.bus_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL sb_start: stall,valid=%b want 10",
               {stall, bus_if.bus_req_valid});
    end
    step();
    idle_inputs();
    n_chk++;
    if ({bus_if.bus_req_valid, bus_if.bus_req_we, stall} !== 3'b111) begin
      n_fail++;
      $display("FAIL sb_req: valid,we,stall=%b want 111",
               {bus_if.bus_req_valid, bus_if.bus_req_we, stall});
    end
    n_chk++;
    if (bus_if.bus_req_addr !== 32'h1000) begin
      n_fail++;
      $display("FAIL sb_addr: got %h want 00001000",
               bus_if.bus_req_addr);
    end
    n_chk++;
    if (bus_if.bus_req_wdata !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL sb_wdata: got %h want a5a5a5a5",
               bus_if.bus_req_wdata);
    end
    n_chk++;
    if (bus_if.bus_req_be !== 4'b1000) begin
      n_fail++;
      $display("FAIL sb_be: got %b want 1000", bus_if.bus_req_be);
    end
    step();
    n_chk++;
    if ({bus_if.bus_req_valid, stall, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL sb_wait: valid,stall,done=%b want 010",
               {bus_if.bus_req_valid, stall, done});
    end
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = 32'h0;
    step();
    bus_if.bus_rsp_valid = 1'b0;
    n_chk++;
    if ({done, stall, access_fault} !== 3'b100) begin
      n_fail++;
      $display("FAIL sb_done: done,stall,fault=%b want 100",
               {done, stall, access_fault});
    end
    step();
    n_chk++;
    if ({done, stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_after: done,stall=%b want 00", {done, stall});
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [8] = '{3'b001, 3'b101, 3'b000, 3'b100,
                             3'b000, 3'b010, 3'b011, 3'b001};
    logic [31:0] as  [8] = '{32'h2002, 32'h2002, 32'h2001, 32'h2003,
                             32'h2003, 32'h2000, 32'h2004, 32'h2000};
    logic [31:0] rds [8] = '{32'h8001_1234, 32'h8001_1234,
                             32'h8001_1234, 32'h8001_1234,
                             32'h8001_1234, 32'hCAFE_F00D,
                             32'h1357_2468, 32'h1234_F00D};
    logic [31:0] exs [8] = '{32'hFFFF_8001, 32'h0000_8001,
                             32'h0000_0012, 32'h0000_0080,
                             32'hFFFF_FF80, 32'hCAFE_F00D,
                             32'h1357_2468, 32'hFFFF_F00D};
    logic        seen;
    logic [31:0] ld;
    logic        flt;
    for (int i = 0; i < 8; i++) begin
      run_access(1'b0, f3s[i], as[i], 32'h0, rds[i], 1'b0,
                 seen, ld, flt);
      n_chk++;
      if ({seen, ld, flt} !== {1'b1, exs[i], 1'b0}) begin
        n_fail++;
        $display("FAIL load_%0d: done=%b data=%h flt=%b want 1 %h 0",
                 i, seen, ld, flt, exs[i]);
      end
    end
  endtask

  task automatic test_misaligned;
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b010, 3'b001, 3'b001};
    logic [31:0] as  [4] = '{32'h2001, 32'h2006, 32'h2003, 32'h2001};
    bus_if.bus_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(wes[i], f3s[i], as[i], 32'h0);
      #1;
      n_chk++;
      if ({stall, bus_if.bus_req_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL mis_start_%0d: stall,valid=%b want 10",
                 i, {stall, bus_if.bus_req_valid});
      end
      step();
      idle_inputs();
      n_chk++;
      if ({done, misaligned_ld, misaligned_st, stall,
           bus_if.bus_req_valid} !== {1'b1, ~wes[i], wes[i], 2'b00}) begin
        n_fail++;
        $display("FAIL mis_done_%0d: d,ld,st,stall,v=%b want %b",
                 i, {done, misaligned_ld, misaligned_st, stall,
                     bus_if.bus_req_valid},
                 {1'b1, ~wes[i], wes[i], 2'b00});
      end
      step();
      n_chk++;
      if ({done, misaligned_ld, misaligned_st} !== 3'b000) begin
        n_fail++;
        $display("FAIL mis_clr_%0d: d,ld,st=%b want 000",
                 i, {done, misaligned_ld, misaligned_st});
      end
    end
  endtask

  task automatic test_ready_stall;
    bus_if.bus_req_ready = 1'b0;
    start_op(1'b1, 3'b001, 32'h3002, 32'h0000_BEEF);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({bus_if.bus_req_valid, stall, bus_if.bus_req_addr,
           bus_if.bus_req_wdata, bus_if.bus_req_be} !==
          {2'b11, 32'h3000, 32'hBEEF_BEEF, 4'b1100}) begin
        n_fail++;
        $display("FAIL hold_%0d: v=%b s=%b a=%h d=%h be=%b",
                 i, bus_if.bus_req_valid, stall, bus_if.bus_req_addr,
                 bus_if.bus_req_wdata, bus_if.bus_req_be);
      end
      step();
    end
    bus_if.bus_req_ready = 1'b1;
    step();
    n_chk++;
    if ({bus_if.bus_req_valid, stall} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_wait: valid,stall=%b want 01",
               {bus_if.bus_req_valid, stall});
    end
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = 32'h0;
    step();
    bus_if.bus_rsp_valid = 1'b0;
    n_chk++;
    if ({done, stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_done: done,stall=%b want 10", {done, stall});
    end
    step();
  endtask

  task automatic test_flush_wait;
    logic        seen;
    logic [31:0] ld;
    logic        flt;
    logic        any_done;
    run_access(1'b0, 3'b010, 32'h4000, 32'h0, 32'h1122_3344, 1'b0,
               seen, ld, flt);
    n_chk++;
    if ({seen, ld} !== {1'b1, 32'h1122_3344}) begin
      n_fail++;
      $display("FAIL fl_pre: done=%b data=%h want 1 11223344", seen, ld);
    end
    any_done = 1'b0;
    start_op(1'b0, 3'b010, 32'h4004, 32'h0);
    step();
    idle_inputs();
    any_done |= done;
    step();
    any_done |= done;
    flush = 1'b1;
    step();
    flush = 1'b0;
    any_done |= done;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_drain: stall=%b want 1", stall);
    end
    step();
    any_done |= done;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = 32'hDEAD_BEEF;
    step();
    bus_if.bus_rsp_valid = 1'b0;
    any_done |= done;
    n_chk++;
    if ({any_done, stall, load_data} !== {2'b00, 32'h1122_3344}) begin
      n_fail++;
      $display("FAIL fl_idle: done=%b stall=%b data=%h want 0 0 11223344",
               any_done, stall, load_data);
    end
    step();
    run_access(1'b0, 3'b010, 32'h4008, 32'h0, 32'h5566_7788, 1'b0,
               seen, ld, flt);
    n_chk++;
    if ({seen, ld} !== {1'b1, 32'h5566_7788}) begin
      n_fail++;
      $display("FAIL fl_next: done=%b data=%h want 1 55667788", seen, ld);
    end
  endtask

  task automatic test_rsp_ignored;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = 32'hFFFF_FFFF;
    step();
    step();
    bus_if.bus_rsp_valid = 1'b0;
    n_chk++;
    if ({done, stall, load_data} !== {2'b00, 32'h5566_7788}) begin
      n_fail++;
      $display("FAIL stray_rsp: done=%b stall=%b data=%h want 0 0 55667788",
               done, stall, load_data);
    end
  endtask

  task automatic test_error;
    logic        seen;
    logic [31:0] ld;
    logic        flt;
    run_access(1'b0, 3'b010, 32'h5000, 32'h0, 32'h0BAD_F00D, 1'b1,
               seen, ld, flt);
    n_chk++;
    if ({seen, flt} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_done: done,fault=%b want 11", {seen, flt});
    end
    n_chk++;
    if ({done, access_fault} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clr: done,fault=%b want 00", {done, access_fault});
    end
  endtask

  task automatic test_reset_wait;
    bus_if.bus_req_ready = 1'b1;
    start_op(1'b0, 3'b010, 32'h6000, 32'h0);
    step();
    idle_inputs();
    step();
    n_chk++;
    if ({stall, load_data} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL rw_pre: stall=%b data=%h want 1 0badf00d",
               stall, load_data);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({stall, done, misaligned_ld, misaligned_st, access_fault,
         bus_if.bus_req_valid, bus_if.bus_req_addr, bus_if.bus_req_be,
         load_data} !== '0) begin
      n_fail++;
      $display("FAIL rw_reset: s=%b d=%b v=%b a=%h be=%b ld=%h want 0",
               stall, done, bus_if.bus_req_valid, bus_if.bus_req_addr,
               bus_if.bus_req_be, load_data);
    end
    step();
    reset = 1'b0;
    step();
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = 32'h1234_5678;
    step();
    bus_if.bus_rsp_valid = 1'b0;
    n_chk++;
    if ({done, stall, load_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL rw_late: done=%b stall=%b data=%h want 0 0 0",
               done, stall, load_data);
    end
    step();
  endtask

  task automatic test_back_to_back;
    logic        seen;
    logic [31:0] ld;
    logic        flt;
    run_access(1'b0, 3'b010, 32'h7000, 32'h0, 32'hA1A2_A3A4, 1'b0,
               seen, ld, flt);
    n_chk++;
    if ({seen, ld} !== {1'b1, 32'hA1A2_A3A4}) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b data=%h want 1 a1a2a3a4", seen, ld);
    end
    start_op(1'b0, 3'b100, 32'h7005, 32'h0);
    #1;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start: stall=%b want 1", stall);
    end
    step();
    idle_inputs();
    n_chk++;
    if ({bus_if.bus_req_valid, bus_if.bus_req_be} !== 5'b1_0010) begin
      n_fail++;
      $display("FAIL b2b_req: valid,be=%b want 10010",
               {bus_if.bus_req_valid, bus_if.bus_req_be});
    end
    step();
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rsp_rdata = 32'h00C3_0000;
    step();
    bus_if.bus_rsp_valid = 1'b0;
    n_chk++;
    if ({done, load_data} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b data=%h want 1 00000000",
               done, load_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_ready_stall();
    test_flush_wait();
    test_rsp_ignored();
    test_error();
    test_reset_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. Consumes the registered EX/MEM outputs: memory control, funct3, physical address, store data.
- Runs one data-bus transaction per memory instruction using valid/ready request and valid response handshakes.
- Stalls the pipeline (hold to EX/MEM and upstream) until the transaction completes.
- Returns aligned, sign/zero-extended load data plus misaligned and access-fault indications to the writeback/trap logic.

Parameters:
XLEN, 32, data/address width; 32 or 64
BE_W, XLEN/8, byte-enable width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  EX/MEM entry valid
mem_read  in  1  load request
mem_write  in  1  store request
funct3  in  3  access size/signedness
addr  in  XLEN  physical address (MMU-translated)
wdata  in  XLEN  store data
flush  in  1  kill current instruction (trap/redirect)
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_req_we  out  1  1=write
bus_req_addr  out  XLEN  address, low log2(BE_W) bits forced 0
bus_req_wdata  out  XLEN  lane-replicated store data
bus_req_be  out  BE_W  byte enables
bus_rsp_valid  in  1  response valid (one per accepted request)
bus_rsp_rdata  in  XLEN  read data
bus_rsp_err  in  1  bus error, qualified by bus_rsp_valid
stall  out  1  hold pipeline
done  out  1  one-cycle completion pulse
load_data  out  XLEN  extended load result
misaligned_ld  out  1  load misaligned, valid with done
misaligned_st  out  1  store/AMO misaligned, valid with done
access_fault  out  1  bus error, valid with done

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE. All outputs 0, including load_data, bus_req_*, stall, done and the fault outputs. Reset mid-transaction abandons it; any late bus response is ignored.
- start = valid_in & (mem_read|mem_write) & ~flush & state==IDLE.
- stall = start | (state != IDLE & state != DONE), combinational. stall is low in DONE, letting EX/MEM advance.
- Misalignment:
  - funct3[1:0]=01 requires addr[0]=0.
  - 10 requires addr[1:0]=0.
  - 11 requires addr[2:0]=0.
  - funct3[1:0]=11 with XLEN=32 is treated as a word access.
- At start: latch funct3, addr low bits, and we=mem_write.
- FSM:
  - IDLE: on start, if misaligned go to DONE with the matching misaligned flag set and issue no bus request; else go to REQ.
  - REQ: bus_req_valid=1. Address, data and be are held stable until bus_req_ready. On ready go to WAIT. On flush before ready, drop valid and go to IDLE.
  - WAIT: on bus_rsp_valid capture load_data and access_fault=bus_rsp_err, then go to DONE. If flush arrives in WAIT, go to DRAIN.
  - DRAIN: on bus_rsp_valid go to IDLE with no done and no load_data update. stall stays high.
  - DONE: done=1 for exactly one cycle. Fault flags are valid this cycle and cleared next cycle. Then go to IDLE.
- load_data holds its last value outside DONE.
- Byte enables:
  - byte: 1<<off
  - half: 2'b11<<off
  - word: 4'hF<<off
  - double: all ones
- Store data: replicated across lanes (byte {BE_W{b}}, half, word likewise).
- Load extraction: sh = bus_rsp_rdata >> (8*off).
  - funct3 000/001/010: sign-extend 8/16/32 bits.
  - funct3 100/101/110: zero-extend 8/16/32 bits.
  - funct3 011: full width.
- Minimum latency: aligned, ready=1, response the next cycle gives start (cycle 0), REQ (1), WAIT (2), DONE (3).
- Back-to-back accesses: IDLE→start can occur the cycle after DONE.
- A bus_rsp_valid outside WAIT/DRAIN is ignored.

Test Plan:
- XLEN=32, SB addr=0x1003 wdata=0x000000A5, ready=1 -> bus_req_be=4'b1000, bus_req_wdata=0xA5A5A5A5, bus_req_addr=0x1000, bus_req_we=1; done one cycle after response; stall low only in the done cycle.
- LH addr=0x2002, rsp rdata=0x8001_1234 -> load_data=0xFFFF8001. Repeat as LHU -> 0x00008001. LB addr=0x2001 -> 0x00000012.
- LW addr=0x2001 -> no bus_req_valid; done and misaligned_ld=1 on the cycle after start; stall high for exactly one cycle. SW addr=0x2006 -> misaligned_st=1.
- bus_req_ready held low 3 cycles in REQ -> bus_req_valid, addr, wdata and be stable all 3 cycles; stall high throughout; completes normally after ready.
- flush during WAIT, response 2 cycles later with rdata=0xDEADBEEF -> no done pulse, load_data unchanged, returns to IDLE; the next LW executes normally.
- Response with bus_rsp_err=1 -> done=1 with access_fault=1, cleared next cycle. Reset asserted in WAIT -> all outputs 0 immediately, state IDLE.
